// File: rtl/ebpc_pkg.sv
// ebpc_pkg: shared widths and decoder state encoding for the EBPC ZNZ decoder
package ebpc_pkg;
  localparam int DATA_W = 8;
  localparam int MAX_ZRLE_LEN = 16;
  localparam int LEN_W = $clog2(MAX_ZRLE_LEN);
  typedef enum logic [2:0] {IDLE, FLAG, RUNLEN, ZEROS, NZ} dec_state_e;
endpackage

// File: rtl/ebpc_znz_decoder_if.sv
// ebpc_znz_decoder_if: block-length, ZNZ, nonzero and output streams of the decoder
interface ebpc_znz_decoder_if #(
  parameter int DATA_W = 8,
  parameter int BLK_W = 16
);
  logic [BLK_W-1:0] len_i;
  logic len_vld_i;
  logic len_rdy_o;
  logic [DATA_W-1:0] znz_data_i;
  logic znz_vld_i;
  logic znz_rdy_o;
  logic [DATA_W-1:0] nz_data_i;
  logic nz_vld_i;
  logic nz_rdy_o;
  logic [DATA_W-1:0] data_o;
  logic last_o;
  logic vld_o;
  logic rdy_i;
  logic err_o;
  modport master (
    output len_i, len_vld_i, znz_data_i, znz_vld_i, nz_data_i, nz_vld_i, rdy_i,
    input len_rdy_o, znz_rdy_o, nz_rdy_o, data_o, last_o, vld_o, err_o
  );
  modport slave (
    input len_i, len_vld_i, znz_data_i, znz_vld_i, nz_data_i, nz_vld_i, rdy_i,
    output len_rdy_o, znz_rdy_o, nz_rdy_o, data_o, last_o, vld_o, err_o
  );
endinterface

// File: rtl/ebpc_znz_bitbuf.sv
// ebpc_znz_bitbuf: holds one ZNZ word and hands out its bits MSB first
module ebpc_znz_bitbuf #(
  parameter int DATA_W = 8,
  parameter int LEN_W = 4,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              sh1_i,
  input  logic              shn_i,
  input  logic              clr_i,
  output logic              bit_o,
  output logic [LEN_W-1:0]  bits_o,
  output logic [CNT_W-1:0]  cnt_o
);
  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear wins over load; load only happens when empty, shifts only when not
  always_comb begin
    word_d = clr_i ? '0 : load_i ? word_i : sh1_i ? word_q << 1 : shn_i ? word_q << LEN_W : word_q;
    cnt_d = clr_i ? '0 : load_i ? CNT_W'(DATA_W) : sh1_i ? cnt_q - CNT_W'(1) : shn_i ? cnt_q - CNT_W'(LEN_W) : cnt_q;
  end
  // word and remaining-bit count registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      cnt_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q <= cnt_d;
    end
  end
  assign bit_o = word_q[DATA_W-1];
  assign bits_o = word_q[DATA_W-1 -: LEN_W];
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ebpc_znz_decoder.sv
// ebpc_znz_decoder: expands ZNZ flags/zero runs into a word stream; EBPC_ZNZ_DEC_ERR_EN enables the clipped-run error flag
module ebpc_znz_decoder
  import ebpc_pkg::*;
#(
  parameter int DATA_W = ebpc_pkg::DATA_W,
  parameter int MAX_ZRLE_LEN = 16,
  parameter int BLK_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  ebpc_znz_decoder_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_ZRLE_LEN);
  localparam int CNT_W = $clog2(DATA_W + 1);
  dec_state_e state_q, state_d;
  logic [BLK_W-1:0] rem_q, rem_d;
  logic [LEN_W-2:0] run_q, run_d;
  logic [LEN_W-1:0] zcnt_q, zcnt_d, gcnt_q, gcnt_d, run_val;
  logic [DATA_W-1:0] data_q, data_d;
  logic vld_q, vld_d, last_q, last_d;
  logic bb_bit, bb_load, bb_sh1, bb_shn, bb_clr;
  logic [LEN_W-1:0] bb_bits;
  logic [CNT_W-1:0] bb_cnt;
  logic slot, len_hs, nz_hs, z_emit, emit, last_word, empty, chain, run_full;
  ebpc_znz_bitbuf #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_bitbuf (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(bb_load), .word_i(bus.znz_data_i),
    .sh1_i(bb_sh1), .shn_i(bb_shn), .clr_i(bb_clr),
    .bit_o(bb_bit), .bits_o(bb_bits), .cnt_o(bb_cnt)
  );
  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: nonzero runs chain back-to-back while the next flag bit is already buffered
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = len_hs ? FLAG : IDLE;
      FLAG:    state_d = empty ? FLAG : bb_bit ? NZ : RUNLEN;
      RUNLEN:  state_d = run_full ? ZEROS : RUNLEN;
      ZEROS:   state_d = !z_emit ? ZEROS : last_word ? IDLE : zcnt_q == '0 ? FLAG : ZEROS;
      NZ:      state_d = !nz_hs ? NZ : last_word ? IDLE : chain ? NZ : FLAG;
      default: state_d = IDLE;
    endcase
  end
  // handshakes and bit-buffer control; run length is taken whole when possible, else bit by bit across words
  always_comb begin
    empty = bb_cnt == '0;
    slot = !vld_q || bus.rdy_i;
    last_word = rem_q == BLK_W'(1);
    bus.len_rdy_o = state_q == IDLE && !rst_i;
    bus.znz_rdy_o = empty && (state_q == FLAG || state_q == RUNLEN);
    bus.nz_rdy_o = state_q == NZ && slot;
    len_hs = bus.len_vld_i && bus.len_rdy_o;
    nz_hs = bus.nz_vld_i && bus.nz_rdy_o;
    z_emit = state_q == ZEROS && slot;
    emit = nz_hs || z_emit;
    chain = nz_hs && !last_word && !empty && bb_bit;
    bb_load = bus.znz_vld_i && bus.znz_rdy_o;
    bb_shn = state_q == RUNLEN && gcnt_q == '0 && bb_cnt >= CNT_W'(LEN_W);
    bb_sh1 = (state_q == FLAG && !empty) || (state_q == RUNLEN && !empty && !bb_shn) || chain;
    bb_clr = emit && last_word;
    run_full = state_q == RUNLEN && !empty && (bb_shn || gcnt_q == LEN_W'(LEN_W - 1));
    run_val = bb_shn ? bb_bits : {run_q, bb_bit};
  end
  // datapath next values: block counter, run gathering, registered output slot
  always_comb begin
    rem_d = len_hs ? bus.len_i : emit ? rem_q - BLK_W'(1) : rem_q;
    run_d = state_q == RUNLEN && !empty ? run_val[LEN_W-2:0] : run_q;
    gcnt_d = state_q != RUNLEN ? '0 : bb_sh1 ? gcnt_q + LEN_W'(1) : gcnt_q;
    zcnt_d = run_full ? run_val : z_emit ? zcnt_q - LEN_W'(1) : zcnt_q;
    data_d = !emit ? data_q : nz_hs ? bus.nz_data_i : '0;
    vld_d = emit || (vld_q && !bus.rdy_i);
    last_d = emit ? last_word : last_q;
  end
  // datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      run_q <= '0;
      gcnt_q <= '0;
      zcnt_q <= '0;
      data_q <= '0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      run_q <= run_d;
      gcnt_q <= gcnt_d;
      zcnt_q <= zcnt_d;
      data_q <= data_d;
      vld_q <= vld_d;
      last_q <= last_d;
    end
  end
  assign bus.data_o = data_q;
  assign bus.vld_o = vld_q;
  assign bus.last_o = last_q;
`ifdef EBPC_ZNZ_DEC_ERR_EN
  logic err_q;
  // sticky flag: a zero run still had words left when the block ended
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (z_emit && last_word && zcnt_q != '0) err_q <= 1'b1;
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule
